// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding mux selects,
// wait-state FSM states and the register index width.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [1:0] FWD_RD  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/fwd_unit.sv
// Combinational forwarding select for one EX-stage source operand.
// The younger result in MEM takes priority over the one in WB.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs,
    input  logic [REG_IDX_W-1:0] rd_m,
    input  logic [REG_IDX_W-1:0] rd_w,
    input  logic                 reg_write_m,
    input  logic                 reg_write_w,
    output logic [1:0]           fwd
);

    always_comb begin
        fwd = FWD_RD;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs))
            fwd = FWD_MEM;
        else if (reg_write_w && (rd_w != '0) && (rd_w == rs))
            fwd = FWD_WB;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: forwarding, load-use,
// branch flush and data-memory wait states with a timeout watchdog.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] Rs1D,
    input  logic [REG_IDX_W-1:0] Rs2D,
    input  logic [REG_IDX_W-1:0] Rs1E,
    input  logic [REG_IDX_W-1:0] Rs2E,
    input  logic [REG_IDX_W-1:0] RdE,
    input  logic [REG_IDX_W-1:0] RdM,
    input  logic [REG_IDX_W-1:0] RdW,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 ResultSrcE0,
    input  logic                 PCSrcE,
    input  logic                 MemReqM,
    input  logic                 MemReadyM,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushW,
    output logic                 MemErr
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]          StallCnt,
    output logic [31:0]          FlushCnt,
    output logic [31:0]          WaitCnt
`endif
);

    state_t     state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic       err_next;
    logic [1:0] fwd_a, fwd_b;
    logic       lw_stall, mem_stall;

    fwd_unit u_fwd_a (
        .rs(Rs1E), .rd_m(RdM), .rd_w(RdW),
        .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .fwd(fwd_a)
    );

    fwd_unit u_fwd_b (
        .rs(Rs2E), .rd_m(RdM), .rd_w(RdW),
        .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .fwd(fwd_b)
    );

    assign lw_stall  = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;
    // Stall already in the cycle that sees the miss, so nothing passes MEM early.
    assign mem_stall = (MemReqM && !MemReadyM) || (state == WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RUN;
            cnt    <= '0;
            MemErr <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            MemErr <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        err_next   = MemErr;
        case (state)
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    state_next = WAIT;
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                cnt_next = cnt + 1'b1;
                if (MemReadyM) begin
                    state_next = RUN;
                end else if (cnt == CNT_W'(TIMEOUT - 2)) begin
                    // Counter reaches TIMEOUT-1 on this edge: give up on the access.
                    err_next   = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        ForwardAE = fwd_a;
        ForwardBE = fwd_b;
        StallF    = lw_stall || mem_stall;
        StallD    = lw_stall || mem_stall;
        StallE    = mem_stall;
        StallM    = mem_stall;
        // EX is held during a memory stall, so a pending branch re-presents later.
        FlushD    = PCSrcE && !mem_stall;
        FlushE    = (lw_stall || PCSrcE) && !mem_stall;
        FlushW    = mem_stall;
        if (reset) begin
            ForwardAE = FWD_RD;
            ForwardBE = FWD_RD;
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            StallM    = 1'b0;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushW    = 1'b1;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCnt <= '0;
            FlushCnt <= '0;
            WaitCnt  <= '0;
        end else begin
            if ((state == RUN) && lw_stall) StallCnt <= StallCnt + 32'd1;
            if ((state == RUN) && PCSrcE)   FlushCnt <= FlushCnt + 32'd1;
            if (StallM)                     WaitCnt  <= WaitCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (default TIMEOUT=64).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] StallCnt, FlushCnt, WaitCnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    wire [6:0] ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr)
`ifdef PIPE_PERF_CNT_EN
        , .StallCnt(StallCnt), .FlushCnt(FlushCnt), .WaitCnt(WaitCnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        RdM = 5; RegWriteM = 1; Rs1E = 5; Rs2E = 5;
        step(); step();
        n_tests++;
        if (ctl !== 7'b0000111) begin
            n_fail++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 7'b0000111);
        end
        n_tests++;
        if ({ForwardAE, ForwardBE} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_fwd got=%b exp=0000", {ForwardAE, ForwardBE});
        end
        n_tests++;
        if (MemErr !== 1'b0) begin
            n_fail++; $display("FAIL reset_memerr got=%b exp=0", MemErr);
        end
        clear_inputs();
        reset = 0;
        step();
    endtask

    task automatic test_forward();
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 0;
        #1;
        n_tests++;
        if ({ForwardAE, ForwardBE} !== 4'b1000) begin
            n_fail++; $display("FAIL fwd_mem_prio got=%b exp=1000", {ForwardAE, ForwardBE});
        end
        RegWriteM = 0;
        #1;
        n_tests++;
        if (ForwardAE !== 2'b01) begin
            n_fail++; $display("FAIL fwd_wb got=%b exp=01", ForwardAE);
        end
        RdM = 0; RegWriteM = 1; RdW = 0; RegWriteW = 1; Rs1E = 0;
        #1;
        n_tests++;
        if ({ForwardAE, ForwardBE} !== 4'b0000) begin
            n_fail++; $display("FAIL fwd_x0 got=%b exp=0000", {ForwardAE, ForwardBE});
        end
        RdM = 3; RdW = 7; Rs1E = 3; Rs2E = 7;
        #1;
        n_tests++;
        if ({ForwardAE, ForwardBE} !== 4'b1001) begin
            n_fail++; $display("FAIL fwd_split got=%b exp=1001", {ForwardAE, ForwardBE});
        end
        RegWriteW = 0;
        #1;
        n_tests++;
        if ({ForwardAE, ForwardBE} !== 4'b1000) begin
            n_fail++; $display("FAIL fwd_nowrite got=%b exp=1000", {ForwardAE, ForwardBE});
        end
        n_tests++;
        if (ctl !== 7'b0000000) begin
            n_fail++; $display("FAIL fwd_ctl_idle got=%b exp=0000000", ctl);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_load_use();
        ResultSrcE0 = 1; RdE = 6; Rs2D = 6; Rs1D = 2;
        #1;
        n_tests++;
        if (ctl !== 7'b1100010) begin
            n_fail++; $display("FAIL lw_rs2 got=%b exp=1100010", ctl);
        end
        step();
        ResultSrcE0 = 0; RdE = 0;
        #1;
        n_tests++;
        if (ctl !== 7'b0000000) begin
            n_fail++; $display("FAIL lw_release got=%b exp=0000000", ctl);
        end
        ResultSrcE0 = 1; RdE = 9; Rs1D = 9; Rs2D = 1;
        #1;
        n_tests++;
        if (ctl !== 7'b1100010) begin
            n_fail++; $display("FAIL lw_rs1 got=%b exp=1100010", ctl);
        end
        RdE = 0; Rs1D = 0;
        #1;
        n_tests++;
        if (ctl !== 7'b0000000) begin
            n_fail++; $display("FAIL lw_x0 got=%b exp=0000000", ctl);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_branch();
        ResultSrcE0 = 1; RdE = 6; Rs2D = 6; PCSrcE = 1;
        #1;
        n_tests++;
        if (ctl !== 7'b0000110) begin
            n_fail++; $display("FAIL br_with_lw got=%b exp=0000110", ctl);
        end
        ResultSrcE0 = 0;
        #1;
        n_tests++;
        if (ctl !== 7'b0000110) begin
            n_fail++; $display("FAIL br_only got=%b exp=0000110", ctl);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_mem_wait();
        int ok;
        MemReqM = 1; MemReadyM = 1;
        #1;
        n_tests++;
        if (ctl !== 7'b0000000) begin
            n_fail++; $display("FAIL mem_zero_wait got=%b exp=0000000", ctl);
        end
        MemReadyM = 0;
        ok = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) PCSrcE = 1;
            if (i == 3) MemReadyM = 1;
            #1;
            if (ctl === 7'b1111001) ok++;
            step();
        end
        n_tests++;
        if (ok !== 4) begin
            n_fail++; $display("FAIL mem_wait_stall_cycles got=%0d exp=4", ok);
        end
        MemReqM = 0; MemReadyM = 0;
        #1;
        n_tests++;
        if (ctl !== 7'b0000110) begin
            n_fail++; $display("FAIL mem_wait_branch_after got=%b exp=0000110", ctl);
        end
        PCSrcE = 0;
        #1;
        n_tests++;
        if ((ctl !== 7'b0000000) || (MemErr !== 1'b0)) begin
            n_fail++; $display("FAIL mem_wait_done got=%b/%b exp=0000000/0", ctl, MemErr);
        end
        step();
    endtask

    task automatic test_timeout();
        int ok;
        ok = 0;
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if ((ctl === 7'b1111001) && (MemErr === 1'b0)) ok++;
            step();
        end
        n_tests++;
        if (ok !== 64) begin
            n_fail++; $display("FAIL timeout_stall_cycles got=%0d exp=64", ok);
        end
        n_tests++;
        if (MemErr !== 1'b1) begin
            n_fail++; $display("FAIL timeout_memerr got=%b exp=1", MemErr);
        end
        MemReqM = 0;
        #1;
        n_tests++;
        if (ctl !== 7'b0000000) begin
            n_fail++; $display("FAIL timeout_back_to_run got=%b exp=0000000", ctl);
        end
        for (int i = 0; i < 5; i++) step();
        n_tests++;
        if (MemErr !== 1'b1) begin
            n_fail++; $display("FAIL timeout_sticky got=%b exp=1", MemErr);
        end
    endtask

    task automatic test_reset_in_wait();
        MemReqM = 1; MemReadyM = 0;
        step(); step();
        reset = 1; MemReqM = 0;
        #1;
        n_tests++;
        if (ctl !== 7'b0000111) begin
            n_fail++; $display("FAIL rst_wait_during got=%b exp=0000111", ctl);
        end
        step();
        reset = 0;
        #1;
        n_tests++;
        if ((ctl !== 7'b0000000) || (MemErr !== 1'b0)) begin
            n_fail++; $display("FAIL rst_wait_after got=%b/%b exp=0000000/0", ctl, MemErr);
        end
`ifdef PIPE_PERF_CNT_EN
        n_tests++;
        if ({StallCnt, FlushCnt, WaitCnt} !== 96'd0) begin
            n_fail++; $display("FAIL rst_perf_cnt got=%0d/%0d/%0d exp=0/0/0", StallCnt, FlushCnt, WaitCnt);
        end
`endif
        step();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RISC-V pipeline datapath.
- Drives the EX-stage forwarding mux selects (SrcA and WriteData).
- Generates per-stage stall/flush for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, covering load-use, taken branch/jump, and multi-cycle data-memory wait.
- Includes a wait-state FSM with timeout watchdog.
- Sits beside the datapath; fed by pipeline register fields.

Parameters:
TIMEOUT, 64, max consecutive MEM_WAIT cycles before the error trap (>=2)
CNT_W, 7, width of wait counter (must hold TIMEOUT)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
Rs1D  in  5  rs1 of instruction in ID
Rs2D  in  5  rs2 of instruction in ID
Rs1E  in  5  rs1 in EX
Rs2E  in  5  rs2 in EX
RdE  in  5  rd in EX
RdM  in  5  rd in MEM
RdW  in  5  rd in WB
RegWriteM  in  1  MEM instr writes rd
RegWriteW  in  1  WB instr writes rd
ResultSrcE0  in  1  EX instr is a load (ResultSrcE[0])
PCSrcE  in  1  taken branch/jump resolved in EX
MemReqM  in  1  MEM instr accesses data memory
MemReadyM  in  1  data memory completes this cycle
ForwardAE  out  2  SrcA select: 00 RD1E, 01 ResultW, 10 ALUResultM
ForwardBE  out  2  WriteData select, same encoding
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
StallE  out  1  hold ID/EX
StallM  out  1  hold EX/MEM
FlushD  out  1  clear IF/ID
FlushE  out  1  clear ID/EX
FlushW  out  1  clear MEM/WB (bubble)
MemErr  out  1  sticky timeout error

Behaviour:
Forwarding (combinational):
- ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E.
- Else ForwardAE=01 if RegWriteW & RdW!=0 & RdW==Rs1E.
- Else 00.
- ForwardBE is identical using Rs2E. MEM has priority over WB.

Load-use:
- lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D) & !PCSrcE.
- In RUN: StallF=StallD=lwStall; FlushE=lwStall|PCSrcE; FlushD=PCSrcE.

FSM states:
- RUN: normal operation.
  - MemReqM & !MemReadyM -> WAIT; clear wait counter.
- WAIT:
  - StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0; the lwStall/PCSrcE terms are masked.
  - Counter increments each cycle.
  - MemReadyM -> RUN. The completing cycle is still a stall cycle; pipeline advances on the next edge.
  - Counter reaches TIMEOUT-1 without ready -> MemErr<=1, return to RUN. The MEM instr completes with undefined data.

Timing and boundaries:
- Entering WAIT also stalls combinationally in the RUN cycle that detects !MemReadyM. Stalls equal MemReqM&!MemReadyM | state==WAIT, so no instruction advances past an unfinished access.
- MemReqM & MemReadyM in RUN: zero-wait, no stall.
- PCSrcE during WAIT: EX is held, so PCSrcE re-presents after the wait; the flush is applied then, and exactly one flush occurs.
- Load-use and taken branch in the same cycle: the branch wins, no stall, FlushD=FlushE=1.
- Reset:
  - state=RUN, counter=0, MemErr=0.
  - While reset is high: all Stall*=0, FlushD=FlushE=FlushW=1, Forward*=00.
  - Reset during WAIT aborts to RUN on the next edge.
- MemErr clears only on reset.

Optional Feature:
Macro PIPE_PERF_CNT_EN.
- Defined: adds output ports StallCnt[31:0], FlushCnt[31:0], WaitCnt[31:0].
  - StallCnt increments on cycles with lwStall in RUN.
  - FlushCnt increments on cycles with PCSrcE in RUN.
  - WaitCnt increments on cycles where StallM=1.
  - All counters wrap modulo 2^32 and reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
Shared package pipe_ctrl_pkg holds:
- FWD_RD=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10 (the datapath mux3 select encoding).
- FSM state enum (RUN, WAIT).
- Register index width constant 5.

Sub-module fwd_unit: purely combinational forwarding for one operand, instanced twice (A and B).

Test Plan:
1. add x5 in MEM (RdM=5, RegWriteM=1), and in WB (RdW=5, RegWriteW=1), Rs1E=5 -> ForwardAE=10; RdM=0 case with Rs1E=0 -> 00.
2. lw x6 in EX (ResultSrcE0=1, RdE=6), Rs2D=6 -> one cycle StallF=StallD=FlushE=1; next cycle with ResultSrcE0=0 -> all 0.
3. PCSrcE=1 with simultaneous load-use -> FlushD=FlushE=1, StallF=StallD=0.
4. MemReqM=1, MemReadyM low 3 cycles then high -> StallF..StallM and FlushW high 4 cycles, state returns RUN, MemErr=0.
5. MemReqM=1, MemReadyM never asserted, TIMEOUT=64 -> MemErr=1 after 64 stall cycles, stays 1 until reset.
6. Reset asserted during WAIT -> next cycle state RUN, stalls 0, MemErr 0; with PIPE_PERF_CNT_EN, all counters 0.
